present_decipher_iter: RTL and testbench
========================================

# present_decipher_iter

Iterative, clocked inverse of the 16-bit/20-bit-key PRESENT-style encipher datapath. Accepts one ciphertext block and master key over a valid/ready handshake and runs the seven inverse rounds one per cycle. Presents the recovered plaintext over a second valid/ready handshake. It is the receive-side counterpart to `present_encipher` and reuses the existing `key_scheduler` for round keys k0..k7.

## Interface
Parameters: none (block and key widths are fixed at 16 and 20 bits).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `ctext`/`master_key` valid.
- `in_ready` out 1: block can accept a new input.
- `ctext` in 16: ciphertext block.
- `master_key` in 20: key; sampled only on the accept edge.
- `out_valid` out 1: `ptext` holds a completed result.
- `out_ready` in 1: consumer takes `ptext`.
- `ptext` out 16: recovered plaintext.
- `busy` out 1: high while rounds are in progress.

## Operation
- Forward round, as defined by `cipher_round`: out = P(S(in ^ key)).
  - S: 4 nibbles through PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - P: bit i moves to 4*i mod 15 for i<15; bit 15 is fixed.
  - Encipher is ctext = R6(…R0(ptext)) ^ k7, where Rj uses kj.
- Inverse round j: state = Sinv(Pinv(state)) ^ kj.
  - Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  - Pinv: bit 4*i mod 15 moves back to bit i.
- Key registration:
  - `master_key` is registered on accept into `key_q`.
  - `key_scheduler` is driven combinationally from `key_q`; its k0..k7 select the round key by counter.
- FSM states:
  - IDLE: `in_ready`=1. On in_valid&in_ready: `state` <= ctext ^ k(master_key)_7, `key_q` <= master_key, `rnd` <= 6, go to BUSY. The k7 term for the load uses the incoming key via a second `key_scheduler` instance or an equivalent computation.
  - BUSY: each cycle `state` <= invround(state, k[rnd]) and `rnd` decrements. When `rnd`==0: `ptext` <= invround result, go to DONE.
  - DONE: `out_valid`=1. On out_ready, go to IDLE. If in_valid is also high in that cycle, accept the new input directly (DONE→BUSY, load as in IDLE).
- `in_ready` = (IDLE) | (DONE & out_ready).
- `ptext` changes only on the final-round edge and is stable while `out_valid`=1.
- `out_valid` never drops without out_ready.
- `ctext` and `master_key` may change freely after the accept edge with no effect on the result.
- `rnd` is 3 bits and never wraps below 0; it leaves BUSY at 0.

## Timing
- Reset (async assert, any state): FSM=IDLE; `out_valid`=0, `busy`=0, `ptext`=16'h0000, `state`=0, `key_q`=0, `rnd`=0. `in_ready`=1 after reset deasserts.
- Reset mid-operation: the in-flight block is discarded and no `out_valid` is produced for it.
- Accept on edge N. BUSY during cycles N+1..N+7. `out_valid`=1 from after edge N+7, giving a latency of 7 cycles from accept to `out_valid`.
- Throughput:
  - Back-to-back via the DONE fast path: 1 block per 8 cycles.
  - With a stalled consumer: results hold indefinitely in DONE.
- `busy` is 1 exactly in BUSY.
- `in_ready` is 0 throughout BUSY; `in_valid` is ignored there.

## Test plan
- Round trip:
  - Stimulus: drive `present_encipher` with ptext=16'h1234, key=20'h0F0F0, and feed its ctext in.
  - Required: `out_valid` rises 7 cycles after accept with `ptext`=16'h1234.
  - Repeat for ptext=16'h0000/key=20'h00000 and ptext=16'hFFFF/key=20'hFFFFF.
- Randomized round trip: 1000 random (ptext, key) pairs through the encipher→this block, with random `out_ready` stalls. Every result equals the original ptext, in order.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_valid` stays 1, `ptext` is unchanged, `in_ready`=0.
  - Release: when `out_ready` goes 1, `out_valid` falls on the next edge.
- Back-to-back: hold `in_valid`=1 with two blocks and `out_ready`=1. The second block is accepted on the same edge the first is consumed, and the second result appears 7 cycles later.
- Input stability: change `ctext`/`master_key` to 16'hDEAD/20'hBEEF0 the cycle after accept. The result still matches the originally accepted values.
- Reset mid-BUSY: assert `rst_n`=0 at round 3.
  - Immediately, without waiting for a clock edge: `out_valid`=0, `busy`=0, `ptext`=0.
  - After release: `in_ready`=1 and no stale output appears.
  - A fresh block then completes correctly.

Source files
------------

// File: rtl/present_decipher_iter.sv
// rtl/present_decipher_iter.sv - iterative 16-bit/20-bit-key PRESENT-style decipher, one inverse round per cycle

module key_scheduler (
    input  logic [19:0] key,
    output logic [15:0] k0,
    output logic [15:0] k1,
    output logic [15:0] k2,
    output logic [15:0] k3,
    output logic [15:0] k4,
    output logic [15:0] k5,
    output logic [15:0] k6,
    output logic [15:0] k7
);

    logic [19:0] reg_chain [0:7];
    logic [19:0] rot;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    // Each step: rotate left by 13, S-box the top nibble, fold the step index into the low nibble.
    always_comb begin
        rot = 20'h0;
        reg_chain[0] = key;
        for (int i = 1; i < 8; i++) begin
            rot = {reg_chain[i-1][6:0], reg_chain[i-1][19:7]};
            rot[19:16] = sbox(rot[19:16]);
            rot[3:0] = rot[3:0] ^ 4'(i);
            reg_chain[i] = rot;
        end
    end

    assign k0 = reg_chain[0][19:4];
    assign k1 = reg_chain[1][19:4];
    assign k2 = reg_chain[2][19:4];
    assign k3 = reg_chain[3][19:4];
    assign k4 = reg_chain[4][19:4];
    assign k5 = reg_chain[5][19:4];
    assign k6 = reg_chain[6][19:4];
    assign k7 = reg_chain[7][19:4];

endmodule

module present_decipher_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ctext,
    input  logic [19:0] master_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] ptext,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t        fsm, fsm_nxt;
    logic [15:0] state;
    logic [19:0] key_q;
    logic [2:0]  rnd;
    logic        accept;
    logic [15:0] k0, k1, k2, k3, k4, k5, k6, k7;
    logic [15:0] round_key;
    logic [15:0] load_k7;
    logic [15:0] p_inv;
    logic [15:0] s_inv;
    logic [15:0] inv_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // k7 of the incoming key is needed on the accept edge, before key_q holds that key.
    function automatic logic [15:0] last_round_key(input logic [19:0] mk);
        logic [19:0] r;
        r = mk;
        for (int i = 1; i < 8; i++) begin
            r = {r[6:0], r[19:7]};
            r[19:16] = sbox(r[19:16]);
            r[3:0] = r[3:0] ^ 4'(i);
        end
        return r[19:4];
    endfunction

    key_scheduler u_key_sched (
        .key (key_q),
        .k0  (k0),
        .k1  (k1),
        .k2  (k2),
        .k3  (k3),
        .k4  (k4),
        .k5  (k5),
        .k6  (k6),
        .k7  (k7)
    );

    assign load_k7 = last_round_key(master_key);

    always_comb begin
        case (rnd)
            3'd0:    round_key = k0;
            3'd1:    round_key = k1;
            3'd2:    round_key = k2;
            3'd3:    round_key = k3;
            3'd4:    round_key = k4;
            3'd5:    round_key = k5;
            3'd6:    round_key = k6;
            default: round_key = k7;
        endcase
    end

    always_comb begin
        p_inv = 16'h0;
        for (int i = 0; i < 15; i++) begin
            p_inv[i] = state[(4 * i) % 15];
        end
        p_inv[15] = state[15];
        s_inv = {sbox_inv(p_inv[15:12]), sbox_inv(p_inv[11:8]),
                 sbox_inv(p_inv[7:4]),   sbox_inv(p_inv[3:0])};
        inv_out = s_inv ^ round_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_nxt = BUSY;
            BUSY:    if (rnd == 3'd0) fsm_nxt = DONE;
            DONE:    if (out_ready) fsm_nxt = in_valid ? BUSY : IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
        out_valid = (fsm == DONE);
        busy      = (fsm == BUSY);
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 16'h0;
            key_q <= 20'h0;
            rnd   <= 3'd0;
            ptext <= 16'h0;
        end else if (accept) begin
            state <= ctext ^ load_k7;
            key_q <= master_key;
            rnd   <= 3'd6;
        end else if (busy) begin
            state <= inv_out;
            if (rnd != 3'd0) begin
                rnd <= rnd - 3'd1;
            end else begin
                ptext <= inv_out;
            end
        end
    end

endmodule

// File: tb/tb_present_decipher_iter.sv
// tb/tb_present_decipher_iter.sv - directed and round-trip bench for present_decipher_iter

module tb_present_decipher_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ctext;
    logic [19:0] master_key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ptext;
    logic        busy;

    int tests;
    int fails;

    present_decipher_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ctext      (ctext),
        .master_key (master_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ptext      (ptext),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] tb_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [15:0] tb_round_key(input logic [19:0] key, input int idx);
        logic [19:0] r;
        r = key;
        for (int i = 1; i <= idx; i++) begin
            r = {r[6:0], r[19:7]};
            r[19:16] = tb_sbox(r[19:16]);
            r[3:0] = r[3:0] ^ 4'(i);
        end
        return r[19:4];
    endfunction

    function automatic logic [15:0] tb_encipher(input logic [15:0] p, input logic [19:0] k);
        logic [15:0] s, t, o;
        s = p;
        for (int j = 0; j < 7; j++) begin
            t = s ^ tb_round_key(k, j);
            t = {tb_sbox(t[15:12]), tb_sbox(t[11:8]), tb_sbox(t[7:4]), tb_sbox(t[3:0])};
            o = 16'h0;
            for (int i = 0; i < 15; i++) o[(4 * i) % 15] = t[i];
            o[15] = t[15];
            s = o;
        end
        return s ^ tb_round_key(k, 7);
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [15:0] c, input logic [19:0] k, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        ctext = c;
        master_key = k;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt, output int busy_cnt);
        cnt = 0;
        busy_cnt = 0;
        while (!out_valid && cnt < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ctext = 16'h0;
        master_key = 20'h0;
        #3;
        tests++;
        if ({out_valid, busy, ptext} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b ptext=%h, want 0 0 0000", out_valid, busy, ptext);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_round_trip(input logic [15:0] p, input logic [19:0] k);
        bit ok;
        int cnt, bcnt;
        send(tb_encipher(p, k), k, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rt_accept: in_ready never seen for ptext %h", p);
        end
        wait_valid(cnt, bcnt);
        tests++;
        if (cnt != 7) begin
            fails++;
            $display("FAIL rt_latency: got %0d cycles, want 7", cnt);
        end
        tests++;
        if (bcnt != 7) begin
            fails++;
            $display("FAIL rt_busy: busy for %0d cycles, want 7", bcnt);
        end
        tests++;
        if (ptext !== p) begin
            fails++;
            $display("FAIL rt_ptext: got %h, want %h (key %h)", ptext, p, k);
        end
        consume();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rt_release: out_valid=%b after consume, want 0", out_valid);
        end
    endtask

    task automatic test_random_round_trip();
        bit ok;
        int cnt, bcnt, stall;
        logic [15:0] p;
        logic [19:0] k;
        for (int n = 0; n < 1000; n++) begin
            p = 16'($urandom);
            k = 20'($urandom);
            send(tb_encipher(p, k), k, ok);
            wait_valid(cnt, bcnt);
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            tests++;
            if (!ok || out_valid !== 1'b1 || ptext !== p) begin
                fails++;
                $display("FAIL random_rt[%0d]: ok=%b valid=%b ptext=%h, want 1 1 %h", n, ok, out_valid, ptext, p);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cnt, bcnt;
        send(tb_encipher(16'hA5C3, 20'h12345), 20'h12345, ok);
        wait_valid(cnt, bcnt);
        in_valid = 1'b1;
        ctext = 16'h1111;
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (out_valid !== 1'b1 || ptext !== 16'hA5C3 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure[%0d]: valid=%b ptext=%h in_ready=%b, want 1 a5c3 0", i, out_valid, ptext, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cnt, bcnt;
        out_ready = 1'b1;
        in_valid = 1'b1;
        ctext = tb_encipher(16'h0F1E, 20'hA1B2C);
        master_key = 20'hA1B2C;
        @(negedge clk);
        ctext = tb_encipher(16'h7E57, 20'h55AA3);
        master_key = 20'h55AA3;
        wait_valid(cnt, bcnt);
        tests++;
        if (cnt != 7 || ptext !== 16'h0F1E || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: cycles=%0d ptext=%h in_ready=%b, want 7 0f1e 1", cnt, ptext, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: valid=%b busy=%b, want 0 1", out_valid, busy);
        end
        wait_valid(cnt, bcnt);
        tests++;
        if (cnt != 7 || ptext !== 16'h7E57) begin
            fails++;
            $display("FAIL b2b_second: cycles=%0d ptext=%h, want 7 7e57", cnt, ptext);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_input_stability();
        bit ok;
        int cnt, bcnt;
        send(tb_encipher(16'h3C69, 20'h0BEEF), 20'h0BEEF, ok);
        ctext = 16'hDEAD;
        master_key = 20'hBEEF0;
        wait_valid(cnt, bcnt);
        tests++;
        if (!ok || ptext !== 16'h3C69) begin
            fails++;
            $display("FAIL input_stability: ok=%b ptext=%h, want 1 3c69", ok, ptext);
        end
        consume();
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        bit stale;
        send(tb_encipher(16'h4242, 20'h9F3D1), 20'h9F3D1, ok);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ptext !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid_busy: valid=%b busy=%b ptext=%h, want 0 0 0000", out_valid, busy, ptext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        out_ready = 1'b0;
        tests++;
        if (stale) begin
            fails++;
            $display("FAIL reset_stale: output or busy activity after reset, want none");
        end
        test_round_trip(16'hC0DE, 20'h13579);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_round_trip(16'h1234, 20'h0F0F0);
        test_round_trip(16'h0000, 20'h00000);
        test_round_trip(16'hFFFF, 20'hFFFFF);
        test_backpressure();
        test_back_to_back();
        test_input_stability();
        test_reset_mid_busy();
        test_random_round_trip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
